// File: rtl/fetch_fifo_reader_if.sv
// Handshake bundle between the fetch FIFO reader, its fill engine, the FIFO
// read port and the fetch stage.
interface fetch_fifo_reader_if #(
    parameter int ADDR_W = 64
) ();
    logic              req_valid_o;
    logic              req_ready_i;
    logic [ADDR_W-1:0] req_addr_o;

    logic              rd_en_o;
    logic [63:0]       rd_data_i;
    logic              rd_empty_i;

    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;

    logic              instr_valid_o;
    logic [31:0]       instr_o;
    logic [ADDR_W-1:0] instr_pc_o;
    logic              instr_ready_i;

    modport master (
        output req_valid_o,
        output req_addr_o,
        output rd_en_o,
        output instr_valid_o,
        output instr_o,
        output instr_pc_o,
        input  req_ready_i,
        input  rd_data_i,
        input  rd_empty_i,
        input  redirect_i,
        input  redirect_pc_i,
        input  instr_ready_i
    );

    modport slave (
        input  req_valid_o,
        input  req_addr_o,
        input  rd_en_o,
        input  instr_valid_o,
        input  instr_o,
        input  instr_pc_o,
        output req_ready_i,
        output rd_data_i,
        output rd_empty_i,
        output redirect_i,
        output redirect_pc_i,
        output instr_ready_i
    );
endinterface

// File: rtl/fetch_fifo_reader.sv
// CPU-side consumer of the fetch FIFO: requests lines, splits 64-bit beats into
// 32-bit instructions. Define FETCH_RD_PERF_EN to add line/dropped-beat counters.
module fetch_fifo_reader #(
    parameter int ADDR_W     = 64,
    parameter int LINE_BEATS = 4
) (
    input  logic                cpu_clk,
    input  logic                cpu_reset,
    fetch_fifo_reader_if.master bus
`ifdef FETCH_RD_PERF_EN
    ,
    output logic [31:0]         perf_lines_o,
    output logic [31:0]         perf_drop_beats_o
`endif
);
    // state    | meaning
    // S_IDLE   | waiting for the first redirect (boot PC)
    // S_REQ    | line request outstanding to the fill engine
    // S_STREAM | popping beats of the requested line, emitting instructions
    // S_DRAIN  | discarding the remaining beats of an abandoned line

    localparam int LINE_BYTES = 8 * LINE_BEATS;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int BEAT_W     = $clog2(LINE_BEATS);
    localparam int CNT_W      = BEAT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_pc;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]    r_drain_cnt;
    logic                r_instr_valid;
    logic [31:0]         r_instr;
    logic [ADDR_W-1:0]   r_instr_pc;

    logic [ADDR_W-1:0]   w_new_pc;
    logic [ADDR_W-1:0]   w_line_base;
    logic [BEAT_W-1:0]   w_target;
    logic                w_streaming;
    logic                w_have_beat;
    logic                w_out_free;
    logic                w_skip;
    logic                w_load;
    logic                w_pop;
    logic                w_last_beat;
    logic                w_req_acc;
    logic [CNT_W-1:0]    w_drain_rem;

    assign w_new_pc    = bus.redirect_pc_i & ~(ADDR_W'(3));
    assign w_line_base = r_pc & ~(ADDR_W'(LINE_BYTES - 1));
    assign w_target    = r_pc[OFF_W-1:3];
    assign w_streaming = (r_state == S_STREAM);
    assign w_have_beat = !bus.rd_empty_i;
    assign w_out_free  = !r_instr_valid || bus.instr_ready_i;
    assign w_req_acc   = (r_state == S_REQ) && bus.req_ready_i;
    assign w_last_beat = (r_beat_cnt == BEAT_W'(LINE_BEATS - 1));

    // r_pc always names the next instruction to emit, so its beat field and
    // bit 2 directly select which beat and half of the head to load.
    assign w_skip = w_streaming && w_have_beat && (r_beat_cnt < w_target);
    assign w_load = w_streaming && w_have_beat && (r_beat_cnt == w_target) && w_out_free;

    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_STREAM: w_pop = w_skip || (w_load && r_pc[2]);
            S_DRAIN:  w_pop = w_have_beat;
            default:  w_pop = 1'b0;
        endcase
    end

    // Beats of the current line still in flight after this cycle's pop.
    assign w_drain_rem = CNT_W'(LINE_BEATS) - CNT_W'(r_beat_cnt) - CNT_W'(w_pop);

    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.redirect_i) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.req_ready_i && bus.redirect_i) begin
                    w_state_nxt = S_DRAIN;
                end else if (bus.req_ready_i) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (bus.redirect_i) begin
                    w_state_nxt = (w_drain_rem == '0) ? S_REQ : S_DRAIN;
                end else if (w_pop && w_last_beat) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_DRAIN: begin
                if (w_pop && (r_drain_cnt == CNT_W'(1))) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            r_pc        <= '0;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.redirect_i) begin
                        r_pc <= w_new_pc;
                    end
                end
                S_REQ: begin
                    if (bus.redirect_i) begin
                        r_pc <= w_new_pc;
                    end
                    if (bus.req_ready_i) begin
                        r_beat_cnt  <= '0;
                        r_drain_cnt <= CNT_W'(LINE_BEATS);
                    end
                end
                S_STREAM: begin
                    if (bus.redirect_i) begin
                        r_pc        <= w_new_pc;
                        r_drain_cnt <= w_drain_rem;
                    end else if (w_load) begin
                        r_pc <= r_pc + ADDR_W'(4);
                    end
                    if (w_pop) begin
                        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (bus.redirect_i) begin
                        r_pc <= w_new_pc;
                    end
                    if (w_pop) begin
                        r_drain_cnt <= r_drain_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

    // Output register only reloads when free, which gives the hold guarantee.
    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
        end else if (bus.redirect_i) begin
            r_instr_valid <= 1'b0;
        end else if (w_load) begin
            r_instr_valid <= 1'b1;
            r_instr       <= r_pc[2] ? bus.rd_data_i[63:32] : bus.rd_data_i[31:0];
            r_instr_pc    <= r_pc;
        end else if (bus.instr_ready_i) begin
            r_instr_valid <= 1'b0;
        end
    end

    assign bus.req_valid_o   = (r_state == S_REQ);
    assign bus.req_addr_o    = w_line_base;
    assign bus.rd_en_o       = w_pop;
    assign bus.instr_valid_o = r_instr_valid;
    assign bus.instr_o       = r_instr;
    assign bus.instr_pc_o    = r_instr_pc;

`ifdef FETCH_RD_PERF_EN
    logic [31:0] r_perf_lines;
    logic [31:0] r_perf_drop;
    logic        w_drop;

    assign w_drop = w_skip || ((r_state == S_DRAIN) && w_pop);

    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            r_perf_lines <= '0;
            r_perf_drop  <= '0;
        end else begin
            if (w_req_acc) begin
                r_perf_lines <= r_perf_lines + 32'd1;
            end
            if (w_drop) begin
                r_perf_drop <= r_perf_drop + 32'd1;
            end
        end
    end

    assign perf_lines_o      = r_perf_lines;
    assign perf_drop_beats_o = r_perf_drop;
`endif

endmodule

// File: tb/tb_fetch_fifo_reader.sv
// Self-checking bench for fetch_fifo_reader: a vector table of redirect targets
// plus directed sequences for stall, redirect, drain and reset corners.
module tb_fetch_fifo_reader;
    logic cpu_clk;
    logic cpu_reset;

    fetch_fifo_reader_if #(.ADDR_W(64)) bus ();

`ifdef FETCH_RD_PERF_EN
    logic [31:0] perf_lines;
    logic [31:0] perf_drop;
`endif

    fetch_fifo_reader #(
        .ADDR_W     (64),
        .LINE_BEATS (4)
    ) dut (
        .cpu_clk           (cpu_clk),
        .cpu_reset         (cpu_reset),
        .bus               (bus.master)
`ifdef FETCH_RD_PERF_EN
        ,
        .perf_lines_o      (perf_lines),
        .perf_drop_beats_o (perf_drop)
`endif
    );

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [63:0] pc;
        logic [63:0] exp_req;
        logic [63:0] exp_first;
        int          exp_n;
        logic [63:0] exp_next;
        bit          toggle;
        bit          slow;
    } row_t;

    row_t        rows [6];
    int          n_tests;
    int          n_fail;
    int          cyc;
    int          pops;
    int          bad_pops;
    bit          ready_toggle;
    bit          feed_slow;
    logic [63:0] fifo_q [$];
    logic [63:0] pend_q [$];
    logic [63:0] e_pc   [$];
    logic [31:0] e_in   [$];
    logic [63:0] acc_q  [$];

    function automatic logic [31:0] f(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.rd_empty_i = (fifo_q.size() == 0);
        bus.rd_data_i  = (fifo_q.size() == 0) ? 64'h0 : fifo_q[0];
    endtask

    task automatic tick();
        logic do_pop;
        #1;
        do_pop = bus.rd_en_o;
        if (do_pop && fifo_q.size() == 0) begin
            bad_pops++;
            do_pop = 1'b0;
        end
        if (bus.instr_valid_o && bus.instr_ready_i) begin
            e_pc.push_back(bus.instr_pc_o);
            e_in.push_back(bus.instr_o);
        end
        if (bus.req_valid_o && bus.req_ready_i) acc_q.push_back(bus.req_addr_o);
        @(posedge cpu_clk);
        #1;
        if (do_pop) begin
            fifo_q.delete(0);
            pops++;
        end
        if (pend_q.size() > 0) begin
            if (!feed_slow) begin
                while (pend_q.size() > 0) begin
                    fifo_q.push_back(pend_q[0]);
                    pend_q.delete(0);
                end
            end else if (cyc % 3 == 0) begin
                fifo_q.push_back(pend_q[0]);
                pend_q.delete(0);
            end
        end
        cyc++;
        if (ready_toggle) bus.instr_ready_i = (cyc % 2 == 0);
        drive_fifo();
    endtask

    task automatic fill_line(input logic [63:0] base);
        for (int n = 0; n < 4; n++) begin
            pend_q.push_back({f(base + 64'(8*n + 4)), f(base + 64'(8*n))});
        end
    endtask

    task automatic wait_req(input string name, input int budget);
        for (int i = 0; i < budget && !bus.req_valid_o; i++) tick();
        check(name, {63'h0, bus.req_valid_o}, 64'h1);
    endtask

    task automatic drain_out();
        for (int i = 0; i < 20 && bus.instr_valid_o; i++) tick();
    endtask

    task automatic do_redirect(input logic [63:0] pc);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = pc;
        tick();
        bus.redirect_i    = 1'b0;
    endtask

    task automatic accept_req();
        bus.req_ready_i = 1'b1;
        tick();
        bus.req_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        cpu_reset         = 1'b1;
        bus.req_ready_i   = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 64'h0;
        bus.instr_ready_i = 1'b1;
        ready_toggle      = 1'b0;
        feed_slow         = 1'b0;
        fifo_q.delete();
        pend_q.delete();
        e_pc.delete();
        e_in.delete();
        acc_q.delete();
        pops = 0;
        drive_fifo();
        repeat (2) @(posedge cpu_clk);
        #1;
        cpu_reset = 1'b0;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        bad_pops = 0;

        rows[0] = '{64'h1000, 64'h1000, 64'h1000, 8, 64'h1020, 1'b0, 1'b0};
        rows[1] = '{64'h1014, 64'h1000, 64'h1014, 3, 64'h1020, 1'b0, 1'b0};
        rows[2] = '{64'h1004, 64'h1000, 64'h1004, 7, 64'h1020, 1'b1, 1'b0};
        rows[3] = '{64'h103C, 64'h1020, 64'h103C, 1, 64'h1040, 1'b0, 1'b1};
        rows[4] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFE0,
                    64'hFFFF_FFFF_FFFF_FFF8, 2, 64'h0, 1'b0, 1'b0};
        rows[5] = '{64'h2003, 64'h2000, 64'h2000, 8, 64'h2020, 1'b1, 1'b1};

        // Reset state
        do_reset();
        check("rst_req_valid",   {63'h0, bus.req_valid_o},   64'h0);
        check("rst_req_addr",    bus.req_addr_o,             64'h0);
        check("rst_rd_en",       {63'h0, bus.rd_en_o},       64'h0);
        check("rst_instr_valid", {63'h0, bus.instr_valid_o}, 64'h0);
        check("rst_instr",       {32'h0, bus.instr_o},       64'h0);
        check("rst_instr_pc",    bus.instr_pc_o,             64'h0);

        // Table: one line fetch per redirect target
        for (int r = 0; r < 6; r++) begin
            do_reset();
            feed_slow    = rows[r].slow;
            ready_toggle = rows[r].toggle;
            do_redirect(rows[r].pc);
            wait_req($sformatf("row%0d_req_seen", r), 50);
            check($sformatf("row%0d_req_addr", r), bus.req_addr_o, rows[r].exp_req);
            accept_req();
            fill_line(rows[r].exp_req);
            wait_req($sformatf("row%0d_next_seen", r), 300);
            check($sformatf("row%0d_next_addr", r), bus.req_addr_o, rows[r].exp_next);
            drain_out();
            check($sformatf("row%0d_count", r), 64'(e_pc.size()), 64'(rows[r].exp_n));
            for (int i = 0; i < e_pc.size() && i < rows[r].exp_n; i++) begin
                check($sformatf("row%0d_pc%0d", r, i), e_pc[i], rows[r].exp_first + 64'(4*i));
                check($sformatf("row%0d_in%0d", r, i), {32'h0, e_in[i]},
                      {32'h0, f(rows[r].exp_first + 64'(4*i))});
            end
            check($sformatf("row%0d_fifo_left", r), 64'(fifo_q.size() + pend_q.size()), 64'h0);
            check($sformatf("row%0d_accepts", r), 64'(acc_q.size()), 64'h1);
        end

        // Consumer stall: output held, no pops
        do_reset();
        bus.instr_ready_i = 1'b0;
        do_redirect(64'h1000);
        wait_req("stall_req_seen", 50);
        accept_req();
        fill_line(64'h1000);
        for (int i = 0; i < 20 && !bus.instr_valid_o; i++) tick();
        check("stall_valid", {63'h0, bus.instr_valid_o}, 64'h1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("stall_pc%0d", k), bus.instr_pc_o, 64'h1000);
            check($sformatf("stall_in%0d", k), {32'h0, bus.instr_o}, {32'h0, f(64'h1000)});
        end
        check("stall_pops", 64'(pops), 64'h0);
        check("stall_fifo", 64'(fifo_q.size()), 64'h4);
        bus.instr_ready_i = 1'b1;
        wait_req("stall_next_seen", 100);
        drain_out();
        check("stall_count", 64'(e_pc.size()), 64'h8);
        if (e_pc.size() == 8) check("stall_last_pc", e_pc[7], 64'h101C);

        // Redirect mid-STREAM after one beat popped
        do_reset();
        do_redirect(64'h1000);
        wait_req("midr_req_seen", 50);
        accept_req();
        pend_q.push_back({f(64'h1004), f(64'h1000)});
        for (int i = 0; i < 20 && pops < 1; i++) tick();
        check("midr_pops1", 64'(pops), 64'h1);
        do_redirect(64'h2000);
        for (int n = 1; n < 4; n++) pend_q.push_back({f(64'h1004 + 64'(8*n)), f(64'h1000 + 64'(8*n))});
        wait_req("midr_req2_seen", 60);
        check("midr_req2_addr", bus.req_addr_o, 64'h2000);
        check("midr_pops4", 64'(pops), 64'h4);
        check("midr_fifo", 64'(fifo_q.size() + pend_q.size()), 64'h0);
        check("midr_no_stale", 64'(e_pc.size()), 64'h2);
`ifdef FETCH_RD_PERF_EN
        check("midr_perf_drop", {32'h0, perf_drop}, 64'h3);
        check("midr_perf_lines", {32'h0, perf_lines}, 64'h1);
`endif
        accept_req();
        fill_line(64'h2000);
        wait_req("midr_req3_seen", 100);
        drain_out();
        check("midr_total", 64'(e_pc.size()), 64'd10);
        if (e_pc.size() > 2) begin
            check("midr_restart_pc", e_pc[2], 64'h2000);
            check("midr_restart_in", {32'h0, e_in[2]}, {32'h0, f(64'h2000)});
        end

        // Redirect together with request acceptance, then redirect in DRAIN
        do_reset();
        do_redirect(64'h1000);
        wait_req("rr_req_seen", 50);
        bus.req_ready_i   = 1'b1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 64'h3000;
        tick();
        bus.req_ready_i   = 1'b0;
        bus.redirect_i    = 1'b0;
        check("rr_accepts", 64'(acc_q.size()), 64'h1);
        pend_q.push_back(64'hDEAD_0001_DEAD_0000);
        pend_q.push_back(64'hDEAD_0003_DEAD_0002);
        repeat (3) tick();
        do_redirect(64'h4000);
        pend_q.push_back(64'hDEAD_0005_DEAD_0004);
        repeat (5) tick();
        check("rr_still_drain", {63'h0, bus.req_valid_o}, 64'h0);
        check("rr_pops3", 64'(pops), 64'h3);
        pend_q.push_back(64'hDEAD_0007_DEAD_0006);
        wait_req("rr_req2_seen", 30);
        check("rr_req2_addr", bus.req_addr_o, 64'h4000);
        check("rr_pops4", 64'(pops), 64'h4);
        check("rr_no_instr", 64'(e_pc.size()), 64'h0);
`ifdef FETCH_RD_PERF_EN
        check("rr_perf_drop", {32'h0, perf_drop}, 64'h4);
`endif

        // Reset asserted mid-STREAM
        do_reset();
        do_redirect(64'h1000);
        wait_req("rst_mid_req_seen", 50);
        accept_req();
        fill_line(64'h1000);
        repeat (3) tick();
        check("rst_mid_pre_valid", {63'h0, bus.instr_valid_o}, 64'h1);
        #3;
        cpu_reset = 1'b1;
        #1;
        check("rst_mid_req_valid", {63'h0, bus.req_valid_o},  64'h0);
        check("rst_mid_req_addr",  bus.req_addr_o,            64'h0);
        check("rst_mid_rd_en",     {63'h0, bus.rd_en_o},      64'h0);
        check("rst_mid_valid",     {63'h0, bus.instr_valid_o}, 64'h0);
        check("rst_mid_instr",     {32'h0, bus.instr_o},      64'h0);
        check("rst_mid_pc",        bus.instr_pc_o,            64'h0);
        fifo_q.delete();
        pend_q.delete();
        pops = 0;
        @(posedge cpu_clk);
        #1;
        cpu_reset = 1'b0;
        fifo_q.push_back(64'h1111_1111_2222_2222);
        fifo_q.push_back(64'h3333_3333_4444_4444);
        drive_fifo();
        repeat (5) tick();
        check("rst_idle_req", {63'h0, bus.req_valid_o}, 64'h0);
        check("rst_idle_pops", 64'(pops), 64'h0);
        check("rst_idle_valid", {63'h0, bus.instr_valid_o}, 64'h0);
        fifo_q.delete();
        drive_fifo();
        do_redirect(64'h5000);
        wait_req("rst_restart_seen", 10);
        check("rst_restart_addr", bus.req_addr_o, 64'h5000);

        check("never_pop_empty", 64'(bad_pops), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
